lsu_ctrl: RTL and testbench

//  Load/store controller between the EX/MEM pipeline stage and the byte-addressed data memory.

---
 rtl/lsu_ctrl_if.sv | 30 +++
 rtl/lsu_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory signals of the load/store controller.
// The slave modport is the controller's view; the master modport is the pipeline plus memory side.
interface lsu_ctrl_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_fault;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_dataW;
   logic [31:0]       mem_dataR;
   logic              mem_R;
   logic              mem_W;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_dataW, mem_R, mem_W
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataR,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_dataW, mem_R, mem_W
   );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: funct3 decode, range/funct3 faults, RMW sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to also fault misaligned H/HU/SH and W/SW accesses.
module lsu_ctrl #(
   parameter int unsigned ADDR_W = 12
) (
   input logic       clk,
   input logic       rst_n,
   lsu_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       dataw_q, dataw_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              fault_q, fault_d;

   logic [ADDR_W:0]   last_off;
   logic [ADDR_W:0]   end_addr;
   logic              hi_fault, range_fault, f3_fault, align_fault, acc_fault;
   logic [31:0]       load_ext;
   logic [31:0]       rmw_data;

   // Legality of the request currently presented, evaluated at accept.
   always_comb begin
      last_off = '0;
      case (bus.req_funct3[1:0])
         2'b01:   last_off = (ADDR_W+1)'(1);
         2'b10,
         2'b11:   last_off = (ADDR_W+1)'(3);
         default: last_off = '0;
      endcase
   end

   assign end_addr    = {1'b0, bus.req_addr[ADDR_W-1:0]} + last_off;
   assign hi_fault    = |bus.req_addr[31:ADDR_W];
   assign range_fault = end_addr[ADDR_W];
   assign f3_fault    = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                        (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
   assign align_fault = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (|bus.req_addr[1:0]));
`else
   assign align_fault = 1'b0;
`endif
   assign acc_fault   = hi_fault || range_fault || f3_fault || align_fault;

   always_comb begin
      load_ext = bus.mem_dataR;
      case (f3_q)
         3'b000:  load_ext = {{24{bus.mem_dataR[7]}}, bus.mem_dataR[7:0]};
         3'b001:  load_ext = {{16{bus.mem_dataR[15]}}, bus.mem_dataR[15:0]};
         3'b100:  load_ext = {24'h0, bus.mem_dataR[7:0]};
         3'b101:  load_ext = {16'h0, bus.mem_dataR[15:0]};
         default: load_ext = bus.mem_dataR;
      endcase
   end

   // Sub-word store merges the new low bytes into the word read back in RD.
   assign rmw_data = f3_q[0] ? {bus.mem_dataR[31:16], wdata_q[15:0]}
                             : {bus.mem_dataR[31:8], wdata_q[7:0]};

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      dataw_d = '0;
      rdata_d = '0;
      fault_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               wdata_d = bus.req_wdata;
               addr_d  = bus.req_addr[ADDR_W-1:0];
               if (acc_fault) begin
                  state_d = StRsp;
                  fault_d = 1'b1;
               end else if (!bus.req_we || (bus.req_funct3[1:0] != 2'b10)) begin
                  state_d = StRd;
               end else begin
                  state_d = StWr;
                  dataw_d = bus.req_wdata;
               end
            end
         end
         StRd: begin
            if (we_q) begin
               state_d = StWr;
               dataw_d = rmw_data;
            end else begin
               state_d = StRsp;
               rdata_d = load_ext;
            end
         end
         StWr:    state_d = StRsp;
         StRsp:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         f3_q    <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         dataw_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         dataw_q <= dataw_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = (state_q == StRsp);
   assign bus.mem_R     = (state_q == StRd);
   assign bus.mem_W     = (state_q == StWr);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_dataW = dataw_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_fault = fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vectors, multi-cycle corner sequences, random traffic.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_ctrl;
   localparam int unsigned AW = 12;
   localparam int MEM_BYTES = 1 << AW;
   localparam logic [127:0] RST_OUTS = 128'h1 << 80;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   lsu_ctrl_if #(.ADDR_W(AW)) bus ();
   lsu_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int errors = 0;
   int checks = 0;

   // Byte-addressed memory: a word access covers bytes addr..addr+3, bytes past the top are absent.
   logic [7:0] mem [MEM_BYTES];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      end else if (bus.mem_W) begin
         for (int i = 0; i < 4; i++)
            if (int'(bus.mem_addr) + i < MEM_BYTES) mem[int'(bus.mem_addr) + i] <= bus.mem_dataW[8*i +: 8];
      end
   end
   always_comb begin
      bus.mem_dataR = '0;
      if (bus.mem_R)
         for (int i = 0; i < 4; i++)
            if (int'(bus.mem_addr) + i < MEM_BYTES) bus.mem_dataR[8*i +: 8] = mem[int'(bus.mem_addr) + i];
   end

   // Protocol watchers: R/W exclusive, and at least two low cycles before each read strobe.
   logic excl_bad = 1'b0;
   logic gap_bad = 1'b0;
   int   low_run = 2;
   always @(negedge clk) begin
      if (bus.mem_R && bus.mem_W) excl_bad <= 1'b1;
      if (bus.mem_R) begin
         if (low_run < 2) gap_bad <= 1'b1;
         low_run <= 0;
      end else begin
         low_run <= (low_run < 100) ? low_run + 1 : low_run;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.mem_addr,
              bus.mem_dataW, bus.mem_R, bus.mem_W};
   endfunction

   // Reference model: memory as a byte array, rules taken directly from the ISA semantics.
   logic [7:0] ref_mem [MEM_BYTES];

   function automatic int size_of(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic void ref_store(input logic [31:0] addr, input logic [31:0] wdata, input int size);
      for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
   endfunction

   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int lat, output logic flt,
                                 output logic [31:0] rd);
      int size;
      logic [31:0] v;
      size = size_of(f3);
      flt = (longint'(addr) + longint'(size) > longint'(MEM_BYTES)) || f3 == 3'b011 ||
            f3 == 3'b110 || f3 == 3'b111 || (we && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      if (size > 1 && (addr % 32'(size)) != 0) flt = 1'b1;
`endif
      rd = '0;
      if (flt) begin
         lat = 1;
      end else if (we) begin
         ref_store(addr, wdata, size);
         lat = (size == 4) ? 2 : 3;
      end else begin
         v = '0;
         for (int i = 0; i < size; i++) v = v + (32'(ref_mem[int'(addr) + i]) << (8 * i));
         if (!f3[2] && size == 1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
         if (!f3[2] && size == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
         rd = v;
         lat = 2;
      end
   endfunction

   // Per-cycle snapshot of the last transaction, index = cycles after the accept edge.
   logic              rec_r [8];
   logic              rec_w [8];
   logic [31:0]       rec_dw [8];
   logic [AW-1:0]     rec_a [8];

   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic flt,
                       output logic [31:0] rd);
      int n = 0;
      lat = 0;
      flt = 1'b0;
      rd = '0;
      for (int k = 0; k < 8; k++) begin
         rec_r[k] = 1'b0; rec_w[k] = 1'b0; rec_dw[k] = '0; rec_a[k] = '0;
      end
      while (!bus.req_ready && n < 10) begin
         @(posedge clk); #1; n++;
      end
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_funct3 = f3;
      bus.req_addr = addr;
      bus.req_wdata = wdata;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         rec_r[k] = bus.mem_R;
         rec_w[k] = bus.mem_W;
         rec_dw[k] = bus.mem_dataW;
         rec_a[k] = bus.mem_addr;
         if (bus.rsp_valid) begin
            lat = k; flt = bus.rsp_fault; rd = bus.rsp_rdata;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        fault;
      logic [31:0] rdata;
      int          lat;
   } vec_t;

   initial begin
      vec_t        vecs[$];
      int          lat, mlat, sel, gap;
      logic        flt, mflt, we;
      logic [2:0]  f3;
      logic [31:0] rd, mrd, addr, wdata;

      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

      vecs.push_back('{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2});
      vecs.push_back('{1'b0, 3'b000, 32'h010, 32'h0, 1'b0, 32'hFFFFFFEF, 2});
      vecs.push_back('{1'b0, 3'b100, 32'h010, 32'h0, 1'b0, 32'h000000EF, 2});
      vecs.push_back('{1'b0, 3'b001, 32'h010, 32'h0, 1'b0, 32'hFFFFBEEF, 2});
      vecs.push_back('{1'b0, 3'b101, 32'h010, 32'h0, 1'b0, 32'h0000BEEF, 2});
      vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF, 2});
      vecs.push_back('{1'b1, 3'b000, 32'h010, 32'h00000055, 1'b0, 32'h0, 3});
      vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'hDEADBE55, 2});
      vecs.push_back('{1'b1, 3'b001, 32'h012, 32'hFFFF1234, 1'b0, 32'h0, 3});
      vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'h1234BE55, 2});
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back('{1'b0, 3'b001, 32'h011, 32'h0, 1'b1, 32'h0, 1});
`else
      vecs.push_back('{1'b0, 3'b001, 32'h011, 32'h0, 1'b0, 32'h000034BE, 2});
`endif
      vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0, 1'b1, 32'h0, 1});
      vecs.push_back('{1'b0, 3'b010, 32'hFFE, 32'h0, 1'b1, 32'h0, 1});
      vecs.push_back('{1'b0, 3'b011, 32'h010, 32'h0, 1'b1, 32'h0, 1});
      vecs.push_back('{1'b1, 3'b100, 32'h010, 32'h0, 1'b1, 32'h0, 1});
      vecs.push_back('{1'b1, 3'b000, 32'hFFF, 32'h00000080, 1'b0, 32'h0, 3});
      vecs.push_back('{1'b0, 3'b000, 32'hFFF, 32'h0, 1'b0, 32'hFFFFFF80, 2});
      vecs.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0, 1'b0, 32'h80000000, 2});
      vecs.push_back('{1'b0, 3'b001, 32'hFFF, 32'h0, 1'b1, 32'h0, 1});
      vecs.push_back('{1'b0, 3'b010, 32'h80000010, 32'h0, 1'b1, 32'h0, 1});
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back('{1'b1, 3'b010, 32'h013, 32'h01020304, 1'b1, 32'h0, 1});
      vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'h1234BE55, 2});
`else
      vecs.push_back('{1'b1, 3'b010, 32'h013, 32'h01020304, 1'b0, 32'h0, 2});
      vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'h0434BE55, 2});
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), RST_OUTS);
      mem_clr = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", outs(), RST_OUTS);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].we && !vecs[i].fault) ref_store(vecs[i].addr, vecs[i].wdata, size_of(vecs[i].f3));
         xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, flt, rd);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_fault", i), flt, vecs[i].fault);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         if (vecs[i].fault) chk($sformatf("vec%0d_no_mem", i), {rec_r[1], rec_w[1]}, 2'b00);
      end

      // SW cycle detail.
      model(1'b1, 3'b010, 32'h020, 32'hCAFEF00D, mlat, mflt, mrd);
      xact(1'b1, 3'b010, 32'h020, 32'hCAFEF00D, lat, flt, rd);
      chk("sw_t1_rw", {rec_r[1], rec_w[1]}, 2'b01);
      chk("sw_t1_dataW", rec_dw[1], 32'hCAFEF00D);
      chk("sw_t1_addr", rec_a[1], 12'h020);
      chk("sw_rsp", {8'(lat), flt}, {8'(mlat), mflt});

      // SB read-modify-write cycle detail.
      model(1'b1, 3'b000, 32'h020, 32'h00000011, mlat, mflt, mrd);
      xact(1'b1, 3'b000, 32'h020, 32'h00000011, lat, flt, rd);
      chk("sb_t1_rd", {rec_r[1], rec_w[1], rec_dw[1]}, {2'b10, 32'h0});
      chk("sb_t2_wr", {rec_r[2], rec_w[2]}, 2'b01);
      chk("sb_t2_dataW", rec_dw[2], 32'hCAFEF011);
      chk("sb_rsp", {8'(lat), flt}, {8'(mlat), mflt});

      // Back-to-back loads with req_valid held high.
      model(1'b0, 3'b010, 32'h010, 32'h0, mlat, mflt, mrd);
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h010;
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("b2b_cyc%0d", k), {bus.req_ready, bus.mem_R, bus.rsp_valid},
             {(k % 3 == 2), (k % 3 == 0), (k % 3 == 1)});
         if (k % 3 == 1) chk($sformatf("b2b_rdata%0d", k), bus.rsp_rdata, mrd);
         if (k == 8) bus.req_valid = 1'b0;
         @(posedge clk); #1;
      end

      // Reset in the WR cycle of an SB: the write never lands.
      model(1'b1, 3'b010, 32'h030, 32'h11223344, mlat, mflt, mrd);
      xact(1'b1, 3'b010, 32'h030, 32'h11223344, lat, flt, rd);
      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_funct3 = 3'b000;
      bus.req_addr = 32'h030;
      bus.req_wdata = 32'h000000AA;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("sbrst_in_wr", bus.mem_W, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("sbrst_memW_drop", bus.mem_W, 1'b0);
      chk("sbrst_outputs", outs(), RST_OUTS);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      model(1'b0, 3'b010, 32'h030, 32'h0, mlat, mflt, mrd);
      xact(1'b0, 3'b010, 32'h030, 32'h0, lat, flt, rd);
      chk("sbrst_readback", rd, mrd);

      // Reset while an SH is in RD: no write.
      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr = 32'h030;
      bus.req_wdata = 32'h0000BBBB;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("shrst_in_rd", bus.mem_R, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("shrst_memR_drop", bus.mem_R, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      xact(1'b0, 3'b010, 32'h030, 32'h0, lat, flt, rd);
      chk("shrst_readback", rd, mrd);

      // Random traffic against the reference model.
      for (int it = 0; it < 300; it++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) addr = 32'($urandom_range(0, 63));
         else if (sel < 9) addr = 32'hFF0 + 32'($urandom_range(0, 15));
         else addr = $urandom;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         wdata = $urandom;
         model(we, f3, addr, wdata, mlat, mflt, mrd);
         xact(we, f3, addr, wdata, lat, flt, rd);
         chk($sformatf("rnd%0d we=%0d f3=%0d addr=%h", it, we, f3, addr),
             {8'(lat), flt, rd}, {8'(mlat), mflt, mrd});
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end

      chk("mem_rw_exclusive", excl_bad, 1'b0);
      chk("mem_r_gap", gap_bad, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
